// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter. Start bit, DATA_W data bits LSB first, optional parity, stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data (sense selected by PARITY_ODD).
module uart_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OS         = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              b_tick,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned TickW = (OS > 1) ? $clog2(OS) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(OS - 1);
  localparam logic [3:0]       DataLast = 4'(DATA_W - 1);
  localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);
  localparam bit CfgOk = (DATA_W >= 5) && (DATA_W <= 9) && (OS >= 2) &&
                         ((STOP_BITS == 1) || (STOP_BITS == 2)) && (PARITY_ODD <= 1);

  if (!CfgOk) begin : g_cfg_err
    $error("uart_tx: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e              state_q, state_d;
  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                bit_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign bit_end = b_tick && (tick_cnt_q == TickLast);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    // Tick counter only runs inside a frame; bit_end wraps it for the next bit.
    if ((state_q != StIdle) && b_tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + TickW'(1);
    end

    case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d    = StStart;
          shreg_d    = tx_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
          parity_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == DataLast) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          bit_cnt_d = '0;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == StopLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is decoded from the next state so the pin comes straight from a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == StIdle);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-level model (tick count across the whole frame) compared every cycle,
// plus directed frames with literal mid-bit samples and timing.
module tb_uart_tx;

  localparam int DW   = 8;
  localparam int OSR  = 16;
  localparam int SB   = 1;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FrameBits  = 1 + DW + PB + SB;
  localparam int FrameTicks = FrameBits * OSR;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       b_tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx, tx_busy, tx_done;

  int total = 0;
  int bad   = 0;
  int tick_div = 1;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(
    .DATA_W    (DW),
    .OS        (OSR),
    .STOP_BITS (SB),
    .PARITY_ODD(PODD)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .b_tick  (b_tick),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  function automatic logic [FrameBits-1:0] make_frame(input logic [7:0] d);
    logic [FrameBits-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+DW] = (^d) ^ (PODD != 0);
`endif
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick strobe: every tick_div clocks.
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge clk);
      tc++;
      if (tc >= tick_div) tc = 0;
      b_tick = (tc == 0);
    end
  end

  // Frame model: whole frame is FrameTicks counted ticks; bit index = ticks / OSR.
  logic [FrameBits-1:0] m_frame;
  bit                   m_busy;
  bit                   m_done;
  int                   m_ticks;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_ticks <= 0;
      m_frame <= '1;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (tx_valid) begin
          m_frame <= make_frame(tx_data);
          m_busy  <= 1'b1;
          m_ticks <= 0;
        end
      end else if (b_tick) begin
        if (m_ticks == FrameTicks - 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_ticks <= 0;
        end else begin
          m_ticks <= m_ticks + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && chk_en) begin
      check("tx", 32'(tx), 32'(m_busy ? m_frame[m_ticks / OSR] : 1'b1));
      check("tx_ready", 32'(tx_ready), 32'(!m_busy));
      check("tx_busy", 32'(tx_busy), 32'(m_busy));
      check("tx_done", 32'(tx_done), 32'(m_done));
    end
  end

  task automatic wait_done(input string name, input int limit);
    int  c;
    bit  got;
    c   = 0;
    got = 1'b0;
    while (!got && c < limit) begin
      @(negedge clk);
      c++;
      got = tx_done;
    end
    check(name, 32'(got), 32'd1);
  endtask

  // Sends d from idle with ticks every clk; samples tx mid-bit. Optionally pokes 0xFF while busy.
  task automatic sample_frame(input logic [7:0] d, input bit inject,
                              output logic [15:0] s, output int dur);
    int c;
    bit got;
    s = '0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    c = 1;
    for (int k = 0; k < FrameBits; k++) begin
      while (c < 8 + OSR * k) begin
        @(negedge clk);
        c++;
      end
      s[k] = tx;
      if (inject && k == 2) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      if (inject && k == 6) begin
        check("busy_ready_low", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
      end
    end
    got = 1'b0;
    while (!got && c < 2000) begin
      @(negedge clk);
      c++;
      got = tx_done;
    end
    check("frame_done_seen", 32'(got), 32'd1);
    dur = c - 1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_done("send_done_seen", 1500 * tick_div);
  endtask

  initial begin
    logic [15:0] s;
    int          dur;
    int          n;
    bit          seen;

    // Pin the model with hand-computed frames.
`ifdef UART_TX_PARITY_EN
    check("model_55", 32'(make_frame(8'h55)), 32'h4AA);
    check("model_07", 32'(make_frame(8'h07)), 32'h60E);
    check("model_03", 32'(make_frame(8'h03)), 32'h406);
`else
    check("model_55", 32'(make_frame(8'h55)), 32'h2AA);
    check("model_81", 32'(make_frame(8'h81)), 32'h302);
`endif

    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    rstn   = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // 0x55, ticks every clk.
    sample_frame(8'h55, 1'b0, s, dur);
`ifdef UART_TX_PARITY_EN
    check("bits_55", 32'(s), 32'h4AA);
    check("dur_55", 32'(dur), 32'd176);
    sample_frame(8'h07, 1'b0, s, dur);
    check("bits_07", 32'(s), 32'h60E);
    sample_frame(8'h03, 1'b0, s, dur);
    check("bits_03", 32'(s), 32'h406);
`else
    check("bits_55", 32'(s), 32'h2AA);
    check("dur_55", 32'(dur), 32'd160);
`endif
    repeat (4) @(negedge clk);

    // Back-to-back with tx_valid held high.
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    check("b2b_first_busy", 32'(tx_ready), 32'd0);
    tx_data = 8'h3C;
    wait_done("b2b_done1_seen", 400);
    check("b2b_ready_on_done", 32'(tx_ready), 32'd1);
    check("b2b_line_idle", 32'(tx), 32'd1);
    @(negedge clk);
    check("b2b_second_start", 32'(tx), 32'd0);
    check("b2b_second_busy", 32'(tx_busy), 32'd1);
    tx_valid = 1'b0;
    wait_done("b2b_done2_seen", 400);
    repeat (3) @(negedge clk);

    // 0xFF offered mid-frame of 0x00 is ignored.
    sample_frame(8'h00, 1'b1, s, dur);
`ifdef UART_TX_PARITY_EN
    check("bits_00_ignore_ff", 32'(s), 32'h400);
`else
    check("bits_00_ignore_ff", 32'(s), 32'h200);
`endif
    repeat (3) @(negedge clk);

    // Reset during data bit 3 (cycles 65..80 after start begins).
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (69) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | tx_done;
    end
    rstn = 1'b1;
    repeat (200) begin
      @(negedge clk);
      seen = seen | tx_done;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    sample_frame(8'h81, 1'b0, s, dur);
`ifdef UART_TX_PARITY_EN
    check("bits_81", 32'(s), 32'h502);
`else
    check("bits_81", 32'(s), 32'h302);
`endif
    repeat (3) @(negedge clk);

    // Ticks every 5 clk: four '1' data bits of 0x0F form one 4*80 clk run.
    tick_div = 5;
    repeat (6) @(negedge clk);
    @(negedge clk);
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (tx !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    n = 1;
    seen = 1'b1;
    while (seen && n < 1000) begin
      @(negedge clk);
      if (tx === 1'b1) n++;
      else seen = 1'b0;
    end
    check("slow_run_0f", 32'(n), 32'd320);
    wait_done("slow_0f_done_seen", 1500);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
